// File: rtl/bytebeat_pkg.sv
// Shared types and helpers for the time-multiplexed bytebeat voice scheduler.
package bytebeat_pkg;

  localparam int PARAM_W    = 16;
  localparam int PCM_W      = 8;
  localparam int MAX_VOICES = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } voice_pick_t;

  // Lowest set bit of mask strictly above cur; cur = -1 gives the lowest enabled voice.
  function automatic voice_pick_t next_voice(input logic [MAX_VOICES-1:0] mask, input int cur);
    voice_pick_t pick;
    pick = '0;
    for (int i = MAX_VOICES - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        pick.found = 1'b1;
        pick.idx   = 5'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bytebeat_voice_scheduler_tick.sv
// Sample-rate prescaler: one-cycle tick every div_i+1 clocks while enabled.
module sample_tick_gen #(
  parameter int DIV_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;

  // Registered tick; a disabled prescaler restarts from zero so the first
  // tick after enabling lands exactly div_i+1 cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (!en_i) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (cnt >= div_i) begin
      cnt    <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/bytebeat_voice_scheduler.sv
// Shares one bytebeat core across NUM_VOICES voices: each sample tick runs a
// round of param/PCM transactions and latches one byte per enabled voice.
module bytebeat_voice_scheduler
  import bytebeat_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int DIV_W      = 9,
  parameter int TIMEOUT    = 15,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic [DIV_W-1:0]            div_i,
  input  logic [NUM_VOICES-1:0]       voice_en_i,
  input  logic [PARAM_W-1:0]          params_i,
  input  logic                        clr_i,
  output logic [VW-1:0]               core_sel_o,
  output logic [PARAM_W-1:0]          core_params_o,
  output logic                        core_params_vld_o,
  input  logic                        core_params_rdy_i,
  input  logic [PCM_W-1:0]            core_pcm_i,
  input  logic                        core_pcm_vld_i,
  output logic                        core_pcm_rdy_o,
  output logic [PCM_W*NUM_VOICES-1:0] pcm_o,
  output logic [NUM_VOICES-1:0]       pcm_stb_o,
  output logic                        busy_o,
  output logic                        overrun_o,
  output logic                        timeout_o
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_t state_q, state_d;
  logic [VW-1:0]         sel_q, sel_d;
  logic [NUM_VOICES-1:0] mask_q;
  logic [PARAM_W-1:0]    params_q;
  logic [WCNT_W-1:0]     wcnt_q;
  logic [NUM_VOICES-1:0][PCM_W-1:0] pcm_q;
  logic [NUM_VOICES-1:0] stb_q;
  logic                  overrun_q;
  logic                  timeout_q;

  logic        tick;
  logic        start;
  logic        capture;
  logic        expire;
  logic        advance;
  voice_pick_t first_pick;
  voice_pick_t next_pick;

  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .div_i  (div_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // The round walks the mask captured at round start, so voice_en_i changes
  // mid-round only affect the next round.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    start      = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    advance    = 1'b0;
    first_pick = next_voice(MAX_VOICES'(voice_en_i), -1);
    next_pick  = next_voice(MAX_VOICES'(mask_q), int'(sel_q));
    case (state_q)
      IDLE: begin
        if (tick && (|voice_en_i)) begin
          start   = 1'b1;
          sel_d   = VW'(first_pick.idx);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (core_params_rdy_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (core_pcm_vld_i) begin
          capture = 1'b1;
          advance = 1'b1;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          advance = 1'b1;
        end
        if (advance) begin
          if (next_pick.found) begin
            sel_d   = VW'(next_pick.idx);
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      params_q <= '0;
      wcnt_q   <= '0;
    end else begin
      if (start) begin
        mask_q   <= voice_en_i;
        params_q <= params_i;
      end
      if (state_q == ISSUE) begin
        wcnt_q <= '0;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  // Sample registers only change on a completed handshake; the strobe is
  // registered so it lines up with the new pcm_o value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_q <= '0;
      stb_q <= '0;
    end else begin
      stb_q <= '0;
      if (capture) begin
        pcm_q[sel_q] <= core_pcm_i;
        stb_q[sel_q] <= 1'b1;
      end
    end
  end

  // Sticky flags: a new event in the same cycle as clr_i keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_i) begin
        overrun_q <= 1'b0;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end else if (clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign core_sel_o        = sel_q;
  assign core_params_o     = params_q;
  assign core_params_vld_o = (state_q == ISSUE);
  assign core_pcm_rdy_o    = (state_q == WAIT);
  assign busy_o            = (state_q != IDLE);
  assign pcm_o             = pcm_q;
  assign pcm_stb_o         = stb_q;
  assign overrun_o         = overrun_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_bytebeat_voice_scheduler.sv
// Scoreboard bench: expected issues and samples are queued as stimulus is
// applied and retired as the scheduler talks to a behavioural core.
module tb_bytebeat_voice_scheduler;

  localparam int NV = 8;
  localparam int DW = 9;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i;
  logic [DW-1:0] div_i;
  logic [NV-1:0] voice_en_i;
  logic [15:0]   params_i;
  logic          clr_i;
  logic [2:0]    core_sel_o;
  logic [15:0]   core_params_o;
  logic          core_params_vld_o;
  logic          core_params_rdy_i;
  logic [7:0]    core_pcm_i = 8'h00;
  logic          core_pcm_vld_i = 1'b0;
  logic          core_pcm_rdy_o;
  logic [8*NV-1:0] pcm_o;
  logic [NV-1:0] pcm_stb_o;
  logic          busy_o;
  logic          overrun_o;
  logic          timeout_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          voice;
    logic [15:0] params;
    logic [7:0]  pcm;
  } exp_t;

  exp_t sel_q[$];
  exp_t pcm_q[$];
  exp_t mon_e;
  logic [7:0] shadow [NV];
  logic [7:0] pcm_base;
  bit         stall_en;
  int         stall_voice;
  int         stall_cycles;
  logic [NV-1:0] onehot;

  bytebeat_voice_scheduler #(
    .NUM_VOICES (NV),
    .DIV_W      (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en_i              (en_i),
    .div_i             (div_i),
    .voice_en_i        (voice_en_i),
    .params_i          (params_i),
    .clr_i             (clr_i),
    .core_sel_o        (core_sel_o),
    .core_params_o     (core_params_o),
    .core_params_vld_o (core_params_vld_o),
    .core_params_rdy_i (core_params_rdy_i),
    .core_pcm_i        (core_pcm_i),
    .core_pcm_vld_i    (core_pcm_vld_i),
    .core_pcm_rdy_o    (core_pcm_rdy_o),
    .pcm_o             (pcm_o),
    .pcm_stb_o         (pcm_stb_o),
    .busy_o            (busy_o),
    .overrun_o         (overrun_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] shadowFlat();
    logic [63:0] flat;
    flat = '0;
    for (int v = 0; v < NV; v++) flat[8*v +: 8] = shadow[v];
    return flat;
  endfunction

  task automatic applyStimulus(input logic en, input logic [DW-1:0] div, input logic [NV-1:0] mask,
                               input logic [15:0] params);
    en_i       = en;
    div_i      = div;
    voice_en_i = mask;
    params_i   = params;
  endtask

  // Queue one round: every enabled voice is issued; the skipped voice yields no sample.
  task automatic pushRound(input logic [NV-1:0] mask, input logic [15:0] params, input int skip);
    exp_t e;
    for (int v = 0; v < NV; v++) begin
      if (mask[v]) begin
        e.voice  = v;
        e.params = params;
        e.pcm    = pcm_base ^ 8'(v);
        sel_q.push_back(e);
        if (v != skip) pcm_q.push_back(e);
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic waitDrained(input string tag, input int limit);
    int n = 0;
    while ((sel_q.size() != 0 || pcm_q.size() != 0) && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_drained"}, 64'(sel_q.size() + pcm_q.size()), 64'd0);
  endtask

  task automatic waitPcmLeft(input string tag, input int left, input int limit);
    int n = 0;
    while (pcm_q.size() > left && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_progress"}, 64'(pcm_q.size() <= left), 64'd1);
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int n = 0;
    while (busy_o && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
    checkOutput({tag, "_params_vld"}, 64'(core_params_vld_o), 64'd0);
    checkOutput({tag, "_pcm_rdy"}, 64'(core_pcm_rdy_o), 64'd0);
    checkOutput({tag, "_sel"}, 64'(core_sel_o), 64'd0);
    checkOutput({tag, "_params"}, 64'(core_params_o), 64'd0);
    checkOutput({tag, "_pcm"}, pcm_o, 64'd0);
    checkOutput({tag, "_stb"}, 64'(pcm_stb_o), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun_o), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout_o), 64'd0);
  endtask

  // Behavioural core: returns pcm_base ^ voice on the cycle after the
  // scheduler starts listening, except for a deliberately stalled voice.
  always @(negedge clk) begin
    core_pcm_vld_i = core_pcm_rdy_o && !(stall_en && core_sel_o == 3'(stall_voice));
    core_pcm_i     = pcm_base ^ {5'b0, core_sel_o};
    if (core_pcm_rdy_o && stall_en && core_sel_o == 3'(stall_voice)) stall_cycles++;
  end

  always @(negedge clk) begin
    if (rst_n && core_params_vld_o && core_params_rdy_i) begin
      checkOutput("issue_pending", 64'(sel_q.size() > 0), 64'd1);
      if (sel_q.size() > 0) begin
        mon_e = sel_q.pop_front();
        checkOutput("core_sel", 64'(core_sel_o), 64'(mon_e.voice));
        checkOutput("core_params", 64'(core_params_o), 64'(mon_e.params));
      end
    end
    if (rst_n && pcm_stb_o != '0) begin
      checkOutput("strobe_pending", 64'(pcm_q.size() > 0), 64'd1);
      if (pcm_q.size() > 0) begin
        mon_e = pcm_q.pop_front();
        shadow[mon_e.voice] = mon_e.pcm;
        onehot = '0;
        onehot[mon_e.voice] = 1'b1;
        checkOutput("pcm_stb", 64'(pcm_stb_o), 64'(onehot));
        checkOutput("pcm_o", pcm_o, shadowFlat());
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    clr_i = 1'b0;
    core_params_rdy_i = 1'b1;
    pcm_base = 8'h00;
    stall_en = 1'b0;
    stall_voice = 0;
    stall_cycles = 0;
    for (int v = 0; v < NV; v++) shadow[v] = 8'h00;
    #1;
    checkResetState("reset");
    waitCycles(2);
    rst_n = 1'b1;

    $display("[TB] test 1: all voices, two rounds, period 20");
    pcm_base = 8'h10;
    pushRound(8'hFF, 16'h1234, -1);
    pushRound(8'hFF, 16'h1234, -1);
    applyStimulus(1'b1, 9'd19, 8'hFF, 16'h1234);
    waitPcmLeft("t1_round1", 8, 80);
    checkOutput("t1_busy_between_rounds", 64'(busy_o), 64'd0);
    waitDrained("t1", 80);
    applyStimulus(1'b0, 9'd19, 8'hFF, 16'h1234);
    waitCycles(3);
    checkOutput("t1_overrun", 64'(overrun_o), 64'd0);
    checkOutput("t1_timeout", 64'(timeout_o), 64'd0);

    $display("[TB] test 2: sparse mask 1010_0100");
    pcm_base = 8'h40;
    pushRound(8'hA4, 16'hBEEF, -1);
    applyStimulus(1'b1, 9'd19, 8'hA4, 16'hBEEF);
    waitDrained("t2", 80);
    applyStimulus(1'b0, 9'd19, 8'hA4, 16'hBEEF);
    waitCycles(3);
    checkOutput("t2_pcm_hold", pcm_o, shadowFlat());

    $display("[TB] test 6: params change mid-round");
    pcm_base = 8'h70;
    pushRound(8'h0F, 16'hA5A5, -1);
    applyStimulus(1'b1, 9'd19, 8'h0F, 16'hA5A5);
    waitPcmLeft("t6", 3, 80);
    params_i = 16'h5A5A;
    waitDrained("t6", 80);
    applyStimulus(1'b0, 9'd19, 8'h0F, 16'h5A5A);
    waitIdle("t6", 20);

    $display("[TB] test 3: voice 3 times out");
    pcm_base = 8'h33;
    stall_en = 1'b1;
    stall_voice = 3;
    stall_cycles = 0;
    checkOutput("t3_timeout_before", 64'(timeout_o), 64'd0);
    pushRound(8'h18, 16'h0C0C, 3);
    applyStimulus(1'b1, 9'd39, 8'h18, 16'h0C0C);
    waitDrained("t3", 120);
    applyStimulus(1'b0, 9'd39, 8'h18, 16'h0C0C);
    waitIdle("t3", 20);
    stall_en = 1'b0;
    checkOutput("t3_timeout_flag", 64'(timeout_o), 64'd1);
    checkOutput("t3_wait_cycles", 64'(stall_cycles), 64'(TO));
    checkOutput("t3_voice3_kept", 64'(pcm_o[31:24]), 64'(shadow[3]));
    clr_i = 1'b1;
    waitCycles(1);
    clr_i = 1'b0;
    checkOutput("t3_timeout_cleared", 64'(timeout_o), 64'd0);

    $display("[TB] test 4: overrun with period 4");
    pcm_base = 8'h55;
    pushRound(8'hFF, 16'h1111, -1);
    applyStimulus(1'b1, 9'd3, 8'hFF, 16'h1111);
    waitPcmLeft("t4", 5, 40);
    checkOutput("t4_overrun_set", 64'(overrun_o), 64'd1);
    en_i = 1'b0;
    waitDrained("t4", 60);
    waitCycles(10);
    checkOutput("t4_busy_after", 64'(busy_o), 64'd0);
    clr_i = 1'b1;
    waitCycles(1);
    clr_i = 1'b0;
    checkOutput("t4_overrun_cleared", 64'(overrun_o), 64'd0);
    stall_en = 1'b1;
    stall_voice = 0;
    pushRound(8'h01, 16'h2222, 0);
    applyStimulus(1'b1, 9'd0, 8'h01, 16'h2222);
    n = 0;
    while (!busy_o && n < 10) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t4_busy_started", 64'(busy_o), 64'd1);
    clr_i = 1'b1;
    waitCycles(3);
    checkOutput("t4_set_wins_over_clr", 64'(overrun_o), 64'd1);
    clr_i = 1'b0;
    en_i = 1'b0;
    waitIdle("t4", 40);
    waitDrained("t4b", 5);
    stall_en = 1'b0;
    clr_i = 1'b1;
    waitCycles(1);
    clr_i = 1'b0;
    checkOutput("t4_overrun_final", 64'(overrun_o), 64'd0);
    checkOutput("t4_timeout_final", 64'(timeout_o), 64'd0);

    $display("[TB] test 5: async reset mid-WAIT on voice 4");
    pcm_base = 8'h99;
    stall_en = 1'b1;
    stall_voice = 4;
    pushRound(8'h1F, 16'h3333, 4);
    applyStimulus(1'b1, 9'd39, 8'hFF, 16'h3333);
    n = 0;
    while (!(core_pcm_rdy_o && core_sel_o == 3'd4) && n < 100) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t5_reached_voice4_wait", 64'(core_pcm_rdy_o && core_sel_o == 3'd4), 64'd1);
    checkOutput("t5_pending_before_reset", 64'(sel_q.size() + pcm_q.size()), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("t5_reset");
    sel_q.delete();
    pcm_q.delete();
    for (int v = 0; v < NV; v++) shadow[v] = 8'h00;
    stall_en = 1'b0;
    applyStimulus(1'b1, 9'd4, 8'h01, 16'h4444);
    pushRound(8'h01, 16'h4444, -1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!core_params_vld_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t5_first_issue_latency", 64'(n), 64'd6);
    waitDrained("t5", 20);
    en_i = 1'b0;
    waitIdle("t5", 20);
    checkOutput("final_pcm", pcm_o, shadowFlat());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
